// File: rtl/avalon_param_bank.sv
// Avalon-MM parameter bank with shadow/active double buffering.
// Software writes shadow copies and then requests a commit. The commit copies
// every shadow channel into its active copy at the same clock edge, either at
// the next engine frame_sync or immediately, so the engine never sees a mixed
// parameter set.
module avalon_param_bank #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 27,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDR_W-1:0]        address,
    input  logic                     chipselect,
    input  logic                     read,
    input  logic                     write_n,
    input  logic [31:0]              writedata,
    input  logic [3:0]               byteenable,
    output logic [31:0]              readdata,
    input  logic                     frame_sync,
    output logic [NUM_CH*DATA_W-1:0] param_out,
    output logic                     param_update,
    output logic                     irq
);

    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NUM_CH);
    localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(NUM_CH + 1);

    // Expand the four byte enables into a per-bit mask over the channel width.
    function automatic logic [DATA_W-1:0] lane_mask(input logic [3:0] be);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < DATA_W; i++) begin
            m[i] = be[i / 8];
        end
        return m;
    endfunction

    logic [DATA_W-1:0] r_shadow [NUM_CH];
    logic [DATA_W-1:0] r_active [NUM_CH];
    logic              r_commit_pending;
    logic              r_irq_en;
    logic              r_irq_flag;
    logic [15:0]       r_commit_cnt;
    logic              r_param_update;
    logic [31:0]       r_readdata;

    logic              w_wr;
    logic              w_rd;
    logic              w_ctrl_wr;
    logic              w_stat_wr;
    logic              w_imm_commit;
    logic              w_sync_commit;
    logic              w_commit;
    logic [DATA_W-1:0] w_mask;
    logic [31:0]       w_rd_mux;
    logic              w_unused_wdata;

    assign w_wr          = chipselect & ~write_n;
    assign w_rd          = chipselect & read;
    assign w_ctrl_wr     = w_wr & (address == CTRL_ADDR) & byteenable[0];
    assign w_stat_wr     = w_wr & (address == STAT_ADDR) & byteenable[0];
    assign w_imm_commit  = w_ctrl_wr & writedata[2];
    assign w_sync_commit = r_commit_pending & frame_sync;
    assign w_commit      = w_imm_commit | w_sync_commit;
    assign w_mask        = lane_mask(byteenable);
    // Data bits above the channel width are intentionally discarded.
    assign w_unused_wdata = &{1'b0, writedata};

    // Shadow registers: byte-lane masked software writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_shadow[k] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_wr && (address == ADDR_W'(k))) begin
                    r_shadow[k] <= (r_shadow[k] & ~w_mask) | (writedata[DATA_W-1:0] & w_mask);
                end else begin
                    r_shadow[k] <= r_shadow[k];
                end
            end
        end
    end

    // Active registers: atomic copy of all shadows on a commit (pre-write shadow values).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_active[k] <= {DATA_W{1'b0}};
            end
        end else if (w_commit) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_active[k] <= r_shadow[k];
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_active[k] <= r_active[k];
            end
        end
    end

    // Commit request, interrupt state, commit counter and update pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_commit_pending <= 1'b0;
            r_irq_en         <= 1'b0;
            r_irq_flag       <= 1'b0;
            r_commit_cnt     <= 16'h0000;
            r_param_update   <= 1'b0;
        end else begin
            // Immediate commit consumes any request; a fresh arm outranks a frame_sync clear.
            if (w_imm_commit) begin
                r_commit_pending <= 1'b0;
            end else if (w_ctrl_wr && writedata[0]) begin
                r_commit_pending <= 1'b1;
            end else if (w_sync_commit) begin
                r_commit_pending <= 1'b0;
            end else begin
                r_commit_pending <= r_commit_pending;
            end

            if (w_ctrl_wr) begin
                r_irq_en <= writedata[1];
            end else begin
                r_irq_en <= r_irq_en;
            end

            // A commit setting the flag beats a concurrent software clear.
            if (w_commit) begin
                r_irq_flag <= 1'b1;
            end else if (w_stat_wr && writedata[0]) begin
                r_irq_flag <= 1'b0;
            end else begin
                r_irq_flag <= r_irq_flag;
            end

            if (w_commit) begin
                r_commit_cnt <= r_commit_cnt + 16'h0001;
            end else begin
                r_commit_cnt <= r_commit_cnt;
            end

            r_param_update <= w_commit;
        end
    end

    // Read mux over shadow channels, CTRL and STATUS; unmapped words read 0.
    always_comb begin
        w_rd_mux = 32'h0000_0000;
        if (address == CTRL_ADDR) begin
            w_rd_mux = {29'h0000_0000, 1'b0, r_irq_en, r_commit_pending};
        end else if (address == STAT_ADDR) begin
            w_rd_mux = {r_commit_cnt, 15'h0000, r_irq_flag};
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                w_rd_mux = w_rd_mux | ((address == ADDR_W'(k)) ? 32'(r_shadow[k]) : 32'h0000_0000);
            end
        end
    end

    // Registered read data, latency one; held when no read is issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= 32'h0000_0000;
        end else if (w_rd) begin
            r_readdata <= w_rd_mux;
        end else begin
            r_readdata <= r_readdata;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_param_out
        assign param_out[g*DATA_W +: DATA_W] = r_active[g];
    end

    assign readdata     = r_readdata;
    assign param_update = r_param_update;
    assign irq          = r_irq_flag & r_irq_en;

endmodule

// File: tb/tb_avalon_param_bank.sv
// Directed self-checking bench for avalon_param_bank (NUM_CH=8, DATA_W=27, ADDR_W=4).
module tb_avalon_param_bank;

    localparam int NUM_CH = 8;
    localparam int DATA_W = 27;
    localparam int ADDR_W = 4;
    localparam int PW     = NUM_CH * DATA_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              read;
    logic              write_n;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;
    logic              frame_sync;
    logic [PW-1:0]     param_out;
    logic              param_update;
    logic              irq;

    int                n_vec  = 0;
    int                n_err  = 0;
    int                pu_cnt = 0;
    logic [PW-1:0]     exp_po = '0;
    logic [31:0]       rv;

    avalon_param_bank #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read(read), .write_n(write_n), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .frame_sync(frame_sync), .param_out(param_out),
        .param_update(param_update), .irq(irq)
    );

    always #5 clk = ~clk;

    // Count param_update pulses seen on the falling edge.
    always @(negedge clk) if (param_update === 1'b1) pu_cnt = pu_cnt + 1;

    task automatic idle();
        chipselect = 1'b0; read = 1'b0; write_n = 1'b1; frame_sync = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d; byteenable = be;
        @(negedge clk);
        idle();
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        d = readdata;
        idle();
    endtask

    task automatic pulse_fs();
        @(negedge clk); frame_sync = 1'b1;
        @(negedge clk); frame_sync = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; idle(); address = '0; writedata = 32'h0; byteenable = 4'h0;
        repeat (3) @(negedge clk);
        n_vec++; if (param_out !== '0) begin n_err++; $display("FAIL rst_param_out: got %h expected 0", param_out); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b expected 0", irq); end
        n_vec++; if (param_update !== 1'b0) begin n_err++; $display("FAIL rst_param_update: got %b expected 0", param_update); end
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL rst_readdata: got %h expected 0", readdata); end
        reset_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), rv);
            n_vec++; if (rv !== 32'h0) begin n_err++; $display("FAIL rst_read addr %0d: got %h expected 0", a, rv); end
        end
    endtask

    task automatic test_commit_sync();
        wr(4'd0, 32'h07FF_FFFF, 4'hF);
        wr(4'd1, 32'h0123_4567, 4'hF);
        wr(4'd8, 32'h0000_0003, 4'hF);
        repeat (2) @(negedge clk);
        n_vec++; if (param_out !== '0) begin n_err++; $display("FAIL armed_no_change: got %h expected 0", param_out); end
        rd(4'd8, rv);
        n_vec++; if (rv !== 32'h3) begin n_err++; $display("FAIL ctrl_armed: got %h expected 00000003", rv); end
        rd(4'd1, rv);
        n_vec++; if (rv !== 32'h0123_4567) begin n_err++; $display("FAIL shadow1: got %h expected 01234567", rv); end
        pu_cnt = 0;
        pulse_fs();
        exp_po[0 +: DATA_W]  = 27'h7FF_FFFF;
        exp_po[27 +: DATA_W] = 27'h123_4567;
        n_vec++; if (param_out !== exp_po) begin n_err++; $display("FAIL sync_commit: got %h expected %h", param_out, exp_po); end
        repeat (3) @(negedge clk);
        n_vec++; if (pu_cnt !== 1) begin n_err++; $display("FAIL sync_pulse_count: got %0d expected 1", pu_cnt); end
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL sync_irq: got %b expected 1", irq); end
        rd(4'd9, rv);
        n_vec++; if (rv !== 32'h0001_0001) begin n_err++; $display("FAIL status1: got %h expected 00010001", rv); end
        rd(4'd8, rv);
        n_vec++; if (rv !== 32'h2) begin n_err++; $display("FAIL ctrl_after_commit: got %h expected 00000002", rv); end
    endtask

    task automatic test_byte_lanes();
        wr(4'd2, 32'hFFFF_FFFF, 4'h3);
        rd(4'd2, rv);
        n_vec++; if (rv !== 32'h0000_FFFF) begin n_err++; $display("FAIL be_low: got %h expected 0000ffff", rv); end
        wr(4'd2, 32'hFFFF_FFFF, 4'hF);
        rd(4'd2, rv);
        n_vec++; if (rv !== 32'h07FF_FFFF) begin n_err++; $display("FAIL be_all: got %h expected 07ffffff", rv); end
        wr(4'd2, 32'h00AB_0000, 4'h4);
        rd(4'd2, rv);
        n_vec++; if (rv !== 32'h07AB_FFFF) begin n_err++; $display("FAIL be_lane2: got %h expected 07abffff", rv); end
        wr(4'd12, 32'hDEAD_BEEF, 4'hF);
        rd(4'd12, rv);
        n_vec++; if (rv !== 32'h0) begin n_err++; $display("FAIL unmapped: got %h expected 0", rv); end
        n_vec++; if (param_out !== exp_po) begin n_err++; $display("FAIL be_active_hold: got %h expected %h", param_out, exp_po); end
    endtask

    task automatic test_coincident_write();
        wr(4'd3, 32'h0000_0AAA, 4'hF);
        wr(4'd8, 32'h0000_0003, 4'hF);
        pulse_fs();
        exp_po[54 +: DATA_W] = 27'h7AB_FFFF;
        exp_po[81 +: DATA_W] = 27'h000_0AAA;
        n_vec++; if (param_out !== exp_po) begin n_err++; $display("FAIL commit2: got %h expected %h", param_out, exp_po); end
        wr(4'd3, 32'h0000_0BBB, 4'hF);
        wr(4'd8, 32'h0000_0003, 4'hF);
        pu_cnt = 0;
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = 4'd3; writedata = 32'h5; byteenable = 4'hF; frame_sync = 1'b1;
        @(negedge clk);
        idle();
        exp_po[81 +: DATA_W] = 27'h000_0BBB;
        n_vec++; if (param_out !== exp_po) begin n_err++; $display("FAIL coincident_active: got %h expected %h", param_out, exp_po); end
        rd(4'd3, rv);
        n_vec++; if (rv !== 32'h5) begin n_err++; $display("FAIL coincident_shadow: got %h expected 00000005", rv); end
        rd(4'd8, rv);
        n_vec++; if (rv !== 32'h2) begin n_err++; $display("FAIL coincident_pending: got %h expected 00000002", rv); end
        n_vec++; if (pu_cnt !== 1) begin n_err++; $display("FAIL coincident_pulse: got %0d expected 1", pu_cnt); end
        pu_cnt = 0;
        pulse_fs();
        repeat (2) @(negedge clk);
        n_vec++; if (param_out !== exp_po) begin n_err++; $display("FAIL idle_fs_active: got %h expected %h", param_out, exp_po); end
        n_vec++; if (pu_cnt !== 0) begin n_err++; $display("FAIL idle_fs_pulse: got %0d expected 0", pu_cnt); end
        rd(4'd9, rv);
        n_vec++; if (rv !== 32'h0003_0001) begin n_err++; $display("FAIL status3: got %h expected 00030001", rv); end
    endtask

    task automatic test_arm_edges();
        pu_cnt = 0;
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = 4'd8; writedata = 32'h3; byteenable = 4'hF; frame_sync = 1'b1;
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        n_vec++; if (param_out !== exp_po) begin n_err++; $display("FAIL arm_with_fs_active: got %h expected %h", param_out, exp_po); end
        n_vec++; if (pu_cnt !== 0) begin n_err++; $display("FAIL arm_with_fs_pulse: got %0d expected 0", pu_cnt); end
        rd(4'd8, rv);
        n_vec++; if (rv !== 32'h3) begin n_err++; $display("FAIL arm_with_fs_ctrl: got %h expected 00000003", rv); end
        pulse_fs();
        exp_po[81 +: DATA_W] = 27'h000_0005;
        n_vec++; if (param_out !== exp_po) begin n_err++; $display("FAIL arm_next_fs: got %h expected %h", param_out, exp_po); end
        wr(4'd3, 32'h0000_0066, 4'hF);
        wr(4'd8, 32'h0000_0003, 4'hF);
        wr(4'd8, 32'h0000_0003, 4'hF);
        repeat (2) @(negedge clk);
        pu_cnt = 0;
        pulse_fs();
        pulse_fs();
        repeat (2) @(negedge clk);
        exp_po[81 +: DATA_W] = 27'h000_0066;
        n_vec++; if (param_out !== exp_po) begin n_err++; $display("FAIL rearm_active: got %h expected %h", param_out, exp_po); end
        n_vec++; if (pu_cnt !== 1) begin n_err++; $display("FAIL rearm_single_pulse: got %0d expected 1", pu_cnt); end
        rd(4'd9, rv);
        n_vec++; if (rv !== 32'h0005_0001) begin n_err++; $display("FAIL status5: got %h expected 00050001", rv); end
    endtask

    task automatic test_immediate();
        wr(4'd4, 32'h0000_1111, 4'hF);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = 4'd8; writedata = 32'h6; byteenable = 4'hF;
        @(negedge clk);
        idle();
        exp_po[108 +: DATA_W] = 27'h000_1111;
        n_vec++; if (param_out !== exp_po) begin n_err++; $display("FAIL imm_active: got %h expected %h", param_out, exp_po); end
        n_vec++; if (param_update !== 1'b1) begin n_err++; $display("FAIL imm_pulse_high: got %b expected 1", param_update); end
        @(negedge clk);
        n_vec++; if (param_update !== 1'b0) begin n_err++; $display("FAIL imm_pulse_low: got %b expected 0", param_update); end
        wr(4'd9, 32'h0000_0001, 4'hF);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear: got %b expected 0", irq); end
        rd(4'd9, rv);
        n_vec++; if (rv !== 32'h0006_0000) begin n_err++; $display("FAIL status6: got %h expected 00060000", rv); end
        wr(4'd8, 32'h0000_0003, 4'hF);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = 4'd9; writedata = 32'h1; byteenable = 4'hF; frame_sync = 1'b1;
        @(negedge clk);
        idle();
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL set_beats_clear: got %b expected 1", irq); end
        rd(4'd9, rv);
        n_vec++; if (rv !== 32'h0007_0001) begin n_err++; $display("FAIL status7: got %h expected 00070001", rv); end
        wr(4'd8, 32'h0000_0003, 4'hF);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = 4'd9; frame_sync = 1'b1;
        @(negedge clk);
        rv = readdata;
        idle();
        n_vec++; if (rv !== 32'h0007_0001) begin n_err++; $display("FAIL read_precommit: got %h expected 00070001", rv); end
        rd(4'd9, rv);
        n_vec++; if (rv !== 32'h0008_0001) begin n_err++; $display("FAIL status8: got %h expected 00080001", rv); end
    endtask

    task automatic test_async_reset();
        wr(4'd5, 32'h0000_0055, 4'hF);
        wr(4'd8, 32'h0000_0003, 4'hF);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_vec++; if (param_out !== '0) begin n_err++; $display("FAIL async_param_out: got %h expected 0", param_out); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL async_irq: got %b expected 0", irq); end
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL async_readdata: got %h expected 0", readdata); end
        @(negedge clk);
        reset_n = 1'b1;
        exp_po = '0;
        pu_cnt = 0;
        pulse_fs();
        repeat (2) @(negedge clk);
        n_vec++; if (param_out !== exp_po) begin n_err++; $display("FAIL post_reset_fs: got %h expected 0", param_out); end
        n_vec++; if (pu_cnt !== 0) begin n_err++; $display("FAIL post_reset_pulse: got %0d expected 0", pu_cnt); end
        rd(4'd8, rv);
        n_vec++; if (rv !== 32'h0) begin n_err++; $display("FAIL post_reset_ctrl: got %h expected 0", rv); end
        rd(4'd5, rv);
        n_vec++; if (rv !== 32'h0) begin n_err++; $display("FAIL post_reset_shadow: got %h expected 0", rv); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = 4'd8; writedata = 32'h4; byteenable = 4'hF;
        repeat (65535) @(negedge clk);
        idle();
        rd(4'd9, rv);
        n_vec++; if (rv !== 32'hFFFF_0001) begin n_err++; $display("FAIL cnt_ffff: got %h expected ffff0001", rv); end
        wr(4'd8, 32'h0000_0004, 4'hF);
        rd(4'd9, rv);
        n_vec++; if (rv !== 32'h0000_0001) begin n_err++; $display("FAIL cnt_wrap: got %h expected 00000001", rv); end
    endtask

    initial begin
        test_reset();
        test_commit_sync();
        test_byte_lanes();
        test_coincident_write();
        test_arm_edges();
        test_immediate();
        test_async_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
